// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one fixed-latency memory port between fetch and data.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] c_lat_init   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_if_ok;
    logic        w_grant;
    logic        w_sel_d;
    logic        w_sample;
    logic [3:0]  r_lat;
    logic [3:0]  r_starve;
    logic        r_owner_d;
    logic        r_flushed;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_if_valid;
    logic        r_d_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    // A fetch raised together with a flush targets a stale PC and is never granted.
    assign w_if_ok = if_req & ~if_flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel_d     = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req || w_if_ok) begin
                    w_grant     = 1'b1;
                    w_sel_d     = d_req && !(w_if_ok && (r_starve == c_starve_max));
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat       <= 4'd0;
            r_starve    <= 4'd0;
            r_owner_d   <= 1'b0;
            r_flushed   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
        end else begin
            r_mem_en   <= w_grant;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;

            if (w_grant) begin
                r_owner_d   <= w_sel_d;
                r_mem_addr  <= w_sel_d ? d_addr : if_addr;
                r_mem_we    <= w_sel_d & d_we;
                r_mem_wdata <= w_sel_d ? d_wdata : 32'd0;
                r_lat       <= c_lat_init;
                if (w_sel_d && if_req) begin
                    if (r_starve != c_starve_max) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end else begin
                    r_starve <= 4'd0;
                end
            end

            if (r_state == S_WAIT) begin
                if (r_lat != 4'd0) begin
                    r_lat <= r_lat - 4'd1;
                end
                if (!r_owner_d && if_flush) begin
                    r_flushed <= 1'b1;
                end
            end

            if (r_state == S_RESP) begin
                r_flushed <= 1'b0;
            end

            // A flush arriving on the sample edge itself still suppresses the fetch.
            if (w_sample) begin
                if (r_owner_d) begin
                    r_d_valid <= 1'b1;
                    if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                end else if (!(r_flushed || if_flush)) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = if_req & ~r_if_valid;
    assign stall_mem = d_req & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and randomized checks against a transaction-timeline model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int SL = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT, and an independent copy the model predicts from.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    // Fixed-latency memory: data is valid only in the cycle ending at the sample edge.
    int          mcnt = 1000;
    logic [31:0] maddr = 32'd0;
    always @(posedge clock) begin
        #1;
        if (mem_en) begin
            maddr = mem_addr;
            mcnt  = 0;
            if (mem_we) mem[mem_addr] = mem_wdata;
        end else if (mcnt < 1000) begin
            mcnt++;
        end
        mem_rdata = (mcnt == L - 1) ? mem_read(maddr) : $urandom();
    end

    // Model: a grant in cycle g yields the response in cycle g+L, port free again at g+L+2.
    int          cyc, g, free_at, m_starve;
    logic        m_busy, m_owner_d, m_we, m_flushed;
    logic [31:0] m_addr, m_wdata;
    logic        x_if_valid, x_d_valid, x_mem_en;
    logic [31:0] x_if_rdata, x_d_rdata;

    task automatic model_reset();
        cyc = 0; g = 0; free_at = 0; m_starve = 0;
        m_busy = 1'b0; m_owner_d = 1'b0; m_we = 1'b0; m_flushed = 1'b0;
        m_addr = 32'd0; m_wdata = 32'd0;
        x_if_valid = 1'b0; x_d_valid = 1'b0; x_mem_en = 1'b0;
        x_if_rdata = 32'd0; x_d_rdata = 32'd0;
    endtask

    // Advance to the next negedge; inputs currently driven are those seen at the last posedge.
    task automatic step_cycle();
        @(negedge clock);
        cyc++;
        x_if_valid = 1'b0;
        x_d_valid  = 1'b0;
        x_mem_en   = 1'b0;
        if (m_busy) begin
            if (!m_owner_d && if_flush && cyc > g && cyc <= g + L) m_flushed = 1'b1;
            if (cyc == g + L) begin
                m_busy = 1'b0;
                if (m_owner_d) begin
                    x_d_valid = 1'b1;
                    if (!m_we) x_d_rdata = ref_read(m_addr);
                end else if (!m_flushed) begin
                    x_if_valid = 1'b1;
                    x_if_rdata = ref_read(m_addr);
                end
            end
        end
        if (cyc >= free_at && (d_req || (if_req && !if_flush))) begin
            m_owner_d = d_req && !(if_req && !if_flush && m_starve == SL);
            x_mem_en  = 1'b1;
            g         = cyc;
            free_at   = cyc + L + 2;
            m_busy    = 1'b1;
            m_flushed = 1'b0;
            m_addr    = m_owner_d ? d_addr : if_addr;
            m_we      = m_owner_d && d_we;
            m_wdata   = m_owner_d ? d_wdata : 32'd0;
            if (m_we) ref_mem[m_addr] = m_wdata;
            m_starve  = (m_owner_d && if_req) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] acc;
        checks++;
        acc = if_rdata | d_rdata | mem_addr | mem_wdata;
        if ({if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem} !== 6'b0 || acc !== 32'd0) begin
            errors++;
            $display("FAIL reset_state flags=%b data_or=%h expected all zero",
                     {if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem}, acc);
        end
        if_req = 1'b1; if_addr = 32'h0000_0080;
        step_cycle();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL reset_pre_grant mem_en=%b addr=%h expected 1/00000080", mem_en, mem_addr);
        end
        step_cycle();
        #2;
        if_req = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        acc = if_rdata | d_rdata | mem_addr | mem_wdata;
        if ({if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem} !== 6'b0 || acc !== 32'd0) begin
            errors++;
            $display("FAIL reset_async flags=%b data_or=%h expected all zero",
                     {if_valid, d_valid, mem_en, mem_we, stall_if, stall_mem}, acc);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step_cycle();
            checks++;
            if ({if_valid, d_valid, mem_en} !== {x_if_valid, x_d_valid, x_mem_en}) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got v/dv/en=%b expected %b", cyc,
                         {if_valid, d_valid, mem_en}, {x_if_valid, x_d_valid, x_mem_en});
            end
        end
    endtask

    task automatic test_single_fetch();
        int t_grant = -1;
        int t_valid = -1;
        preload(32'h40, 32'h2408_0005);
        if_req = 1'b1; if_addr = 32'h40;
        for (int i = 0; i < 20 && if_req; i++) begin
            step_cycle();
            checks++;
            if (mem_en !== x_mem_en || if_valid !== x_if_valid || stall_if !== !x_if_valid) begin
                errors++;
                $display("FAIL fetch_timing cyc=%0d got en/v/stall=%b%b%b expected %b%b%b", cyc,
                         mem_en, if_valid, stall_if, x_mem_en, x_if_valid, !x_if_valid);
            end
            if (mem_en && t_grant < 0) begin
                t_grant = cyc;
                checks++;
                if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_issue addr=%h we=%b expected 00000040/0", mem_addr, mem_we);
                end
            end
            if (if_valid && t_valid < 0) begin
                t_valid = cyc;
                checks++;
                if (if_rdata !== 32'h2408_0005) begin
                    errors++;
                    $display("FAIL fetch_data got %h expected 24080005", if_rdata);
                end
            end
            if (x_if_valid) if_req = 1'b0;
        end
        checks++;
        if (t_grant < 0 || t_valid - t_grant != L) begin
            errors++;
            $display("FAIL fetch_latency grant=%0d valid=%0d expected distance %0d", t_grant, t_valid, L);
        end
    endtask

    task automatic test_priority();
        logic [31:0] gaddr [2];
        int          gcyc  [2];
        int          n = 0;
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
        for (int i = 0; i < 40 && (if_req || d_req); i++) begin
            step_cycle();
            checks++;
            if (mem_en !== x_mem_en || if_valid !== x_if_valid || d_valid !== x_d_valid ||
                d_rdata !== x_d_rdata || if_rdata !== x_if_rdata) begin
                errors++;
                $display("FAIL prio_cycle cyc=%0d got en/v/dv=%b%b%b d=%h i=%h expected %b%b%b d=%h i=%h",
                         cyc, mem_en, if_valid, d_valid, d_rdata, if_rdata,
                         x_mem_en, x_if_valid, x_d_valid, x_d_rdata, x_if_rdata);
            end
            if (mem_en && n < 2) begin
                gaddr[n] = mem_addr;
                gcyc[n]  = cyc;
                n++;
            end
            if (x_if_valid) if_req = 1'b0;
            if (x_d_valid) d_req = 1'b0;
        end
        checks++;
        if (n != 2 || gaddr[0] !== 32'h100 || gaddr[1] !== 32'h44 || gcyc[1] - gcyc[0] != L + 2) begin
            errors++;
            $display("FAIL prio_order grants=%0d first=%h second=%h gap=%0d expected 2/00000100/00000044/%0d",
                     n, gaddr[0], gaddr[1], gcyc[1] - gcyc[0], L + 2);
        end
    endtask

    task automatic test_store();
        int t_grant = -1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && d_req; i++) begin
            step_cycle();
            if (mem_en && t_grant < 0) begin
                t_grant = cyc;
                checks++;
                if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL store_issue we=%b wdata=%h addr=%h expected 1/deadbeef/00000200",
                             mem_we, mem_wdata, mem_addr);
                end
            end
            if (x_d_valid) begin
                checks++;
                if (d_valid !== 1'b1 || cyc - t_grant != L || t_grant < 0) begin
                    errors++;
                    $display("FAIL store_done d_valid=%b latency=%0d expected 1/%0d", d_valid, cyc - t_grant, L);
                end
                checks++;
                if (d_rdata !== x_d_rdata || if_rdata !== x_if_rdata) begin
                    errors++;
                    $display("FAIL store_rdata_hold d=%h i=%h expected d=%h i=%h",
                             d_rdata, if_rdata, x_d_rdata, x_if_rdata);
                end
                d_req = 1'b0;
            end
        end
        d_we = 1'b0;
        d_req = 1'b1;
        for (int i = 0; i < 20 && d_req; i++) begin
            step_cycle();
            if (x_d_valid) begin
                checks++;
                if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL store_readback d_valid=%b d_rdata=%h expected 1/deadbeef", d_valid, d_rdata);
                end
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_starvation();
        int n = 0;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int i = 0; i < 120 && (if_req || d_req); i++) begin
            step_cycle();
            checks++;
            if (mem_en !== x_mem_en || mem_addr !== m_addr) begin
                errors++;
                $display("FAIL starve_cycle cyc=%0d got en=%b addr=%h expected %b/%h",
                         cyc, mem_en, mem_addr, x_mem_en, m_addr);
            end
            if (mem_en && n < 10) begin
                checks++;
                if ((mem_addr == 32'h80 || mem_addr == 32'h84) !== (n % 5 == 4)) begin
                    errors++;
                    $display("FAIL starve_order grant=%0d addr=%h expected fetch=%0d", n, mem_addr, n % 5 == 4);
                end
                n++;
            end
            if (x_d_valid) begin
                if (n < 10) d_addr = d_addr + 32'd4;
                else d_req = 1'b0;
            end
            if (x_if_valid) begin
                if (n < 10) if_addr = 32'h84;
                else if_req = 1'b0;
            end
        end
        checks++;
        if (n < 10) begin
            errors++;
            $display("FAIL starve_count grants=%0d expected at least 10", n);
        end
    endtask

    task automatic test_flush();
        int          pulses = 0;
        logic [31:0] second = 32'd0;
        int          issues = 0;
        preload(32'h500, 32'h1234_5678);
        preload(32'h600, 32'h0BAD_F00D);
        if_req = 1'b1; if_addr = 32'h500;
        for (int i = 0; i < 30 && if_req; i++) begin
            step_cycle();
            if_flush = 1'b0;
            checks++;
            if (if_valid !== x_if_valid || if_rdata !== x_if_rdata) begin
                errors++;
                $display("FAIL flush_cycle cyc=%0d got v=%b i=%h expected v=%b i=%h",
                         cyc, if_valid, if_rdata, x_if_valid, x_if_rdata);
            end
            if (if_valid) pulses++;
            if (mem_en) begin
                issues++;
                if (issues == 2) second = mem_addr;
            end
            if (x_mem_en && m_addr == 32'h500) begin
                if_flush = 1'b1;
                if_addr  = 32'h600;
            end
            if (x_if_valid) if_req = 1'b0;
        end
        checks++;
        if (pulses != 1 || second !== 32'h600 || if_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL flush_result pulses=%0d retarget=%h data=%h expected 1/00000600/0badf00d",
                     pulses, second, if_rdata);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            step_cycle();
            checks++;
            if ({if_valid, d_valid, mem_en} !== {x_if_valid, x_d_valid, x_mem_en}) begin
                errors++;
                $display("FAIL rand_strobes cyc=%0d got v/dv/en=%b expected %b", cyc,
                         {if_valid, d_valid, mem_en}, {x_if_valid, x_d_valid, x_mem_en});
            end
            checks++;
            if (if_rdata !== x_if_rdata || d_rdata !== x_d_rdata) begin
                errors++;
                $display("FAIL rand_rdata cyc=%0d got i=%h d=%h expected i=%h d=%h",
                         cyc, if_rdata, d_rdata, x_if_rdata, x_d_rdata);
            end
            checks++;
            if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rand_port cyc=%0d got a=%h we=%b wd=%h expected a=%h we=%b wd=%h",
                         cyc, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
            end
            checks++;
            if (stall_if !== (if_req && !x_if_valid) || stall_mem !== (d_req && !x_d_valid)) begin
                errors++;
                $display("FAIL rand_stall cyc=%0d got %b%b expected %b%b", cyc, stall_if, stall_mem,
                         if_req && !x_if_valid, d_req && !x_d_valid);
            end
            if_flush = 1'b0;
            if (x_if_valid) if_req = 1'b0;
            if (x_d_valid) d_req = 1'b0;
            if (m_busy && !m_owner_d && $urandom_range(0, 5) == 0) begin
                if_flush = 1'b1;
                if_addr  = rand_addr();
            end
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1'b1;
                if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = $urandom();
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        test_reset();
        test_single_fetch();
        test_priority();
        test_store();
        test_starvation();
        test_flush();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the memory stage (MEM).
- MEM-stage requests carry LW/SW effective addresses produced by the ALU stage.
- Issues one transaction at a time to a fixed-latency memory, returns read data to the winning requester, and drives stall signals to the pipeline.
- Data requests have priority over fetch, with a starvation guard for fetch and a flush hook for taken branches.

Parameters:
- MEM_LATENCY, 2, edges from the mem_en cycle to the arbiter sampling mem_rdata; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_valid or if_flush
- if_addr  in  [0:31]  fetch address, stable while if_req
- if_flush  in  1  taken branch (ALU bt): discard any pending or in-flight fetch
- d_req  in  1  data request; level, held until d_valid
- d_we  in  1  1 = store (SW), 0 = load (LW)
- d_addr  in  [0:31]  data address
- d_wdata  in  [0:31]  store data
- if_rdata  out  [0:31]  fetched instruction
- if_valid  out  1  one-cycle pulse, if_rdata valid
- d_rdata  out  [0:31]  load data
- d_valid  out  1  one-cycle pulse: load data valid, or store done
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  d_req & ~d_valid
- mem_en  out  1  one-cycle transaction strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  [0:31]  memory address
- mem_wdata  out  [0:31]  memory write data
- mem_rdata  in  [0:31]  memory read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All registered outputs, starve_cnt, lat_cnt and the owner/flushed flags are 0. Any in-flight response is discarded: no valid pulse follows reset release.
- States: IDLE, WAIT, RESP.
- IDLE, at an edge where d_req|if_req:
  - Select data if d_req && !(if_req && starve_cnt==STARVE_LIMIT); otherwise select fetch.
  - Register mem_en=1, mem_addr, mem_we (d_we for data, 0 for fetch), mem_wdata (d_wdata, else 0). Record the owner.
  - lat_cnt=MEM_LATENCY-1; go to WAIT.
  - if_req with if_flush high on the same edge is not granted.
- mem_en is high exactly one cycle. mem_addr, mem_we and mem_wdata hold until the next grant.
- WAIT:
  - Decrement lat_cnt each edge.
  - On the edge where lat_cnt==0, sample mem_rdata into the owner's rdata register.
  - Assert the owner's valid for the next cycle; go to RESP.
  - For MEM_LATENCY=1, this is the first edge after the mem_en cycle.
- RESP:
  - Valid is high for this one cycle. Requests are ignored here; requesters drop or change req during this cycle.
  - Go to IDLE next edge.
- Latency: grant edge to valid cycle = MEM_LATENCY edges. Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- Starvation counter:
  - Data grant with if_req high: starve_cnt++, saturating at STARVE_LIMIT.
  - Fetch grant, or data grant with if_req low: starve_cnt=0.
- Flush:
  - if_flush high in any cycle while a fetch is in WAIT sets flushed.
  - The response still completes, but if_valid is suppressed and if_rdata is not updated.
  - flushed clears in RESP.
  - if_flush has no effect on data transactions.
- Stores: mem_we=1 with mem_en; d_valid pulses at the same latency as loads; d_rdata is unchanged.
- rdata registers hold their last value between transactions.
- stall_if and stall_mem are combinational from the req inputs and registered valid signals; they must not depend on mem_rdata.

Test Plan:
- Reset/idle: reset_n=0 mid-WAIT of a fetch. Required: all outputs 0 immediately; after release with no req, no valid pulse and mem_en stays 0.
- Single fetch, MEM_LATENCY=2: if_req, if_addr=0x0000_0040, memory returns 0x2408_0005. Required: mem_en one cycle with mem_addr=0x40, mem_we=0; if_valid exactly 2 edges after the grant with if_rdata=0x2408_0005; stall_if high until then.
- Priority: if_req and d_req (d_we=0, d_addr=0x100) asserted the same edge. Required: the data transaction issues first; fetch issues on the first IDLE edge after RESP.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF. Required: mem_we=1, mem_wdata=0xDEADBEEF with mem_en; d_valid pulses after MEM_LATENCY; if_rdata and d_rdata unchanged.
- Starvation, STARVE_LIMIT=4: if_req held while d_req is re-asserted every transaction. Required: 4 data grants, then the 5th grant goes to fetch; starve_cnt returns to 0.
- Flush: assert if_flush during a fetch's WAIT, returned data 0x1234_5678. Required: no if_valid and if_rdata keeps its old value; a subsequent fetch to the new target completes normally.
